// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID->EX pipeline stage register.
package id_ex_stage_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CTRL_W_DEF = 10;

  // Bit offsets inside the decoded control bundle
  localparam int unsigned CTRL_SPARE      = 0;
  localparam int unsigned CTRL_WRITE_REG  = 1;
  localparam int unsigned CTRL_MEM_TO_REG = 2;
  localparam int unsigned CTRL_WRITE_MEM  = 3;
  localparam int unsigned CTRL_ALUC_LSB   = 4;
  localparam int unsigned CTRL_SHIFT      = 8;
  localparam int unsigned CTRL_ALU_IMM    = 9;

  typedef logic [DATA_W_DEF-1:0] alu_bus_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_bus_t;

  typedef struct packed {
    logic       alu_imm;
    logic       shift;
    logic [3:0] aluc;
    logic       write_mem;
    logic       mem_to_reg;
    logic       write_reg;
    logic       spare;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/id_ex_stage_slot.sv
// One pipeline slot: a valid bit plus a W-bit data register.
module pipe_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  // Clear wins over load; data is only written on a real load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX stage register with valid/ready handshake, flush and optional skid slot.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N_OPR  = 2,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned SKID   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [N_OPR*DATA_W-1:0] in_opr,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [N_OPR*DATA_W-1:0] out_opr,
  output logic [1:0]              occupancy
);

  localparam int unsigned OPR_W  = N_OPR * DATA_W;
  localparam int unsigned SLOT_W = CTRL_W + OPR_W;

  stage_state_e      state_q, state_d;
  logic [SLOT_W-1:0] in_data, m_d, m_q, s_q;
  logic              m_load, m_clear, m_valid;
  logic              s_load, s_clear, s_valid;
  logic              accept, pop;

  assign in_data = {in_ctrl, in_opr};
  assign accept  = in_valid & in_ready;
  assign pop     = m_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  // Next state and slot control; flush overrides every other action
  always_comb begin
    state_d = state_q;
    m_d     = in_data;
    m_load  = 1'b0;
    m_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          m_load  = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          m_load = 1'b1;
        end else if (accept && (SKID != 0)) begin
          state_d = ST_FULL;
          s_load  = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
          m_clear = 1'b1;
        end
      end
      ST_FULL: begin
        if (pop && s_valid) begin
          state_d = ST_ONE;
          m_d     = s_q;
          m_load  = 1'b1;
          s_clear = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      m_load  = 1'b0;
      s_load  = 1'b0;
      m_clear = 1'b1;
      s_clear = 1'b1;
    end
  end

  pipe_slot #(.W(SLOT_W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (m_load),
    .clear (m_clear),
    .d     (m_d),
    .q     (m_q),
    .valid (m_valid)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;

      pipe_slot #(.W(SLOT_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (s_load),
        .clear (s_clear),
        .d     (in_data),
        .q     (s_q),
        .valid (s_valid)
      );

      // Registered ready: ID never sees a combinational path from EX
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) in_ready_q <= 1'b0;
        else      in_ready_q <= (state_d != ST_FULL);
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      logic alive_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) alive_q <= 1'b0;
        else      alive_q <= 1'b1;
      end
      assign s_q      = '0;
      assign s_valid  = 1'b0;
      assign in_ready = alive_q & (~m_valid | out_ready);
    end
  endgenerate

  // Bubble mask keeps write_reg/write_mem low whenever nothing is valid
  assign out_valid = m_valid;
  assign out_ctrl  = m_q[SLOT_W-1 -: CTRL_W] & {CTRL_W{m_valid}};
  assign out_opr   = m_q[OPR_W-1:0];
  assign occupancy = state_q;

endmodule
